// File: rtl/muladd_pkg.sv
// Shared constants, FSM state type and helpers for the 2-bit muladd LUT dot-product sequencer.
// Holds the code encoding, LUT offset and output width, the lane-address pack function and the pair product.
package muladd_pkg;

    // Activation/weight code encoding: 00=-3, 01=-1, 10=+1, 11=+3
    localparam logic [1:0] CODE_NEG3 = 2'b00;
    localparam logic [1:0] CODE_NEG1 = 2'b01;
    localparam logic [1:0] CODE_POS1 = 2'b10;
    localparam logic [1:0] CODE_POS3 = 2'b11;

    localparam int LUT_OFFSET = 18;
    localparam int U_W        = 5;
    localparam int LANE_AW    = 10;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DRAIN,
        DONE
    } state_e;

    // Magnitude 3 (as opposed to 1)
    function automatic logic code_big(input logic [1:0] c);
        return !((c == CODE_NEG1) || (c == CODE_POS1));
    endfunction

    function automatic logic code_neg(input logic [1:0] c);
        return (c == CODE_NEG3) || (c == CODE_NEG1);
    endfunction

    // Signed product of one element, built from sign and magnitude
    // so no multiplier is inferred. A zero flag kills the activation.
    function automatic logic signed [4:0] pair_prod(
        input logic       z,
        input logic [1:0] a,
        input logic [1:0] w
    );
        logic [3:0] mag;
        logic       neg;
        case ({code_big(a), code_big(w)})
            2'b00:   mag = 4'd1;
            2'b11:   mag = 4'd9;
            default: mag = 4'd3;
        endcase
        neg = code_neg(a) ^ code_neg(w);
        if (z) begin
            return 5'sd0;
        end
        return neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    function automatic logic [LANE_AW-1:0] lane_pack(
        input logic       z0,
        input logic [1:0] a0,
        input logic [1:0] w0,
        input logic       z1,
        input logic [1:0] a1,
        input logic [1:0] w1
    );
        return {z0, a0, w0, z1, a1, w1};
    endfunction

endpackage

// File: rtl/muladd2_lut_ext.sv
// One LUT lane: two element products plus offset, halved into an unsigned code.
// Ports: addr_i = {z0,a0,w0,z1,a1,w1}; u_o = (p0 + p1 + 18) >> 1, range 0..18.
module muladd2_lut_ext
    import muladd_pkg::*;
(
    input  logic [LANE_AW-1:0] addr_i,
    output logic [U_W-1:0]     u_o
);

    logic signed [4:0] p0;
    logic signed [4:0] p1;
    logic [6:0]        t;

    always_comb begin
        p0 = pair_prod(addr_i[9], addr_i[8:7], addr_i[6:5]);
        p1 = pair_prod(addr_i[4], addr_i[3:2], addr_i[1:0]);
        // Two odd products give an even sum, so the halving is exact.
        // A single zero-flagged element makes it odd; the half unit is dropped.
        t   = {{2{p0[4]}}, p0} + {{2{p1[4]}}, p1} + 7'(LUT_OFFSET);
        u_o = U_W'(t >> 1);
    end

endmodule

// File: rtl/muladd2_dot_seq.sv
// Dot-product sequencer: streams beats of P element pairs into LUT lanes, accumulates, removes the offset.
// Ports: clk/rst/clr, beat stream (in_valid/in_ready/in_act/in_zero/in_wgt/in_last), result stream, busy, err_len.
module muladd2_dot_seq
    import muladd_pkg::*;
#(
    parameter  int K_ELEMS       = 64,
    parameter  int PAIRS_PER_CYC = 4,
    localparam int BEATS         = K_ELEMS / (2 * PAIRS_PER_CYC),
    localparam int RES_W         = $clog2(9 * K_ELEMS + 1) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4*PAIRS_PER_CYC-1:0] in_act,
    input  logic [2*PAIRS_PER_CYC-1:0] in_zero,
    input  logic [4*PAIRS_PER_CYC-1:0] in_wgt,
    input  logic                       in_last,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [RES_W-1:0]           res_data,
    output logic                       busy,
    output logic                       err_len
);

    localparam int P     = PAIRS_PER_CYC;
    localparam int ACC_W = $clog2(9 * K_ELEMS + 1);
    localparam int S_W   = $clog2(18 * P + 1);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [S_W-1:0]     s1_q, s1_d;
    logic               s1v_q, s1v_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic               err_q, err_d;

    logic [U_W-1:0]     u_w [P];
    logic [S_W-1:0]     lane_sum;
    logic [RES_W-1:0]   two_acc;
    logic               beat_hs;
    logic               res_hs;
    logic               last_beat;

    for (genvar j = 0; j < P; j++) begin : g_lane
        logic [LANE_AW-1:0] addr;
        assign addr = lane_pack(in_zero[2*j],   in_act[4*j +: 2],   in_wgt[4*j +: 2],
                                in_zero[2*j+1], in_act[4*j+2 +: 2], in_wgt[4*j+2 +: 2]);
        muladd2_lut_ext u_lane (
            .addr_i (addr),
            .u_o    (u_w[j])
        );
    end

    always_comb begin
        lane_sum = '0;
        for (int j = 0; j < P; j++) begin
            lane_sum = lane_sum + S_W'(u_w[j]);
        end
    end

    assign in_ready  = (state_q == IDLE) || (state_q == ACC);
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_data  = res_q;
    assign err_len   = err_q;

    // clr wins over any handshake in the same cycle
    assign beat_hs   = in_valid && in_ready && !clr;
    assign res_hs    = res_valid && res_ready && !clr;
    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (beat_hs) begin
                    state_d = last_beat ? DRAIN : ACC;
                end
            end
            ACC: begin
                if (beat_hs && last_beat) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: state_d = DONE;
            DONE: begin
                if (res_hs) begin
                    state_d = IDLE;
                end
            end
        endcase
        if (clr) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        s1_d  = s1_q;
        s1v_d = beat_hs;
        res_d = res_q;
        err_d = beat_hs && (in_last != last_beat);
        if (beat_hs) begin
            cnt_d = last_beat ? '0 : cnt_q + 1'b1;
            s1_d  = lane_sum;
        end
        // First beat of a vector starts a fresh sum; S1 is empty then.
        if (state_q == IDLE && beat_hs) begin
            acc_d = '0;
        end else if (s1v_q) begin
            acc_d = acc_q + ACC_W'(s1_q);
        end
        // DRAIN is the cycle the last S1 entry lands, so use acc_d.
        two_acc = {acc_d, 1'b0};
        if (state_q == DRAIN) begin
            res_d = two_acc - RES_W'(9 * K_ELEMS);
        end
        if (clr) begin
            cnt_d = '0;
            acc_d = '0;
            s1v_d = 1'b0;
            res_d = res_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            s1_q    <= '0;
            s1v_q   <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            s1_q    <= s1_d;
            s1v_q   <= s1v_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

endmodule
